// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the five-stage pipeline: tracks in-flight destinations,
// stalls on RAW hazards, holds for multi-cycle mul/div, and drains then halts on a trap.
module pipeline_hazard_ctrl #(
    parameter int FORWARDING = 1,
    parameter int MD_LAT     = 4,
    parameter int DRAIN_CYC  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_rf_enable,
    input  logic        id_load_instr,
    input  logic        id_muldiv,
    input  logic        id_annul_slot,
    input  logic        id_ta_instr,
    input  logic        trap_ack,
    output logic        pc_le,
    output logic        npc_le,
    output logic        if_le,
    output logic        if_squash,
    output logic        nop_sel,
    output logic        halted,
    output logic [15:0] stall_count
);

    localparam int CNT_MAX = (MD_LAT > DRAIN_CYC) ? MD_LAT : DRAIN_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {RUN, MD_WAIT, DRAIN, HALT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               stall_inc;
    logic               hazard;

    // Scoreboard slots: p0 = EX, p1 = MEM, p2 = WB
    logic               ex_vld_p0, mem_vld_p1, wb_vld_p2;
    logic [4:0]         ex_rd_p0, mem_rd_p1, wb_rd_p2;
    logic               ex_load_p0;

    // Only a load in EX stalls when results are forwarded; otherwise any in-flight writer does.
    function automatic logic raw_hit(input logic [4:0] rs);
        if (rs == 5'd0)
            return 1'b0;
        if (FORWARDING != 0)
            return ex_vld_p0 && ex_load_p0 && (ex_rd_p0 == rs);
        return (ex_vld_p0 && (ex_rd_p0 == rs)) ||
               (mem_vld_p1 && (mem_rd_p1 == rs)) ||
               (wb_vld_p2 && (wb_rd_p2 == rs));
    endfunction

    assign hazard = (state_q == RUN) && id_valid &&
                    ((id_use_rs1 && raw_hit(id_rs1)) || (id_use_rs2 && raw_hit(id_rs2)));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_le     = 1'b0;
        npc_le    = 1'b0;
        if_le     = 1'b0;
        if_squash = 1'b0;
        nop_sel   = 1'b1;
        halted    = 1'b0;
        stall_inc = 1'b0;
        case (state_q)
            RUN: begin
                if (hazard) begin
                    stall_inc = 1'b1;
                end else begin
                    pc_le   = 1'b1;
                    npc_le  = 1'b1;
                    if_le   = 1'b1;
                    nop_sel = 1'b0;
                    if (id_valid && id_muldiv) begin
                        state_d = MD_WAIT;
                        cnt_d   = CNT_W'(MD_LAT - 1);
                    end else if (id_valid && id_ta_instr) begin
                        state_d = DRAIN;
                        cnt_d   = CNT_W'(DRAIN_CYC);
                    end else if (id_valid && id_annul_slot) begin
                        if_squash = 1'b1;
                    end
                end
            end
            MD_WAIT: begin
                stall_inc = 1'b1;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = RUN;
            end
            DRAIN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = HALT;
            end
            HALT: begin
                halted = 1'b1;
                if (trap_ack)
                    state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        // Hold everything quiet while reset is asserted
        if (!reset) begin
            pc_le     = 1'b0;
            npc_le    = 1'b0;
            if_le     = 1'b0;
            if_squash = 1'b0;
            nop_sel   = 1'b1;
            halted    = 1'b0;
            stall_inc = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            stall_count <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall_inc && (stall_count != 16'hFFFF))
                stall_count <= stall_count + 16'd1;
        end
    end

    // ---- Scoreboard stage boundary: ID -> EX -> MEM -> WB ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_vld_p0  <= 1'b0;
            mem_vld_p1 <= 1'b0;
            wb_vld_p2  <= 1'b0;
        end else begin
            ex_vld_p0  <= id_valid && id_rf_enable && (id_rd != 5'd0) && !nop_sel;
            mem_vld_p1 <= ex_vld_p0;
            wb_vld_p2  <= mem_vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        ex_rd_p0   <= id_rd;
        ex_load_p0 <= id_load_instr;
        mem_rd_p1  <= ex_rd_p0;
        wb_rd_p2   <= mem_rd_p1;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (forwarding on/off) share stimulus and are
// checked every cycle against a history-based model, plus hand-computed directed pins.
module tb_pipeline_hazard_ctrl;

    localparam int MD_LAT    = 4;
    localparam int DRAIN_CYC = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_use_rs1, id_use_rs2, id_rf_enable, id_load_instr;
    logic        id_muldiv, id_annul_slot, id_ta_instr, trap_ack;
    logic [4:0]  id_rs1, id_rs2, id_rd;

    logic [1:0]  pc_w, npc_w, if_w, sq_w, nop_w, halt_w;
    logic [15:0] sc_w [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.FORWARDING(1), .MD_LAT(MD_LAT), .DRAIN_CYC(DRAIN_CYC)) dut_fwd (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_rf_enable(id_rf_enable), .id_load_instr(id_load_instr), .id_muldiv(id_muldiv),
        .id_annul_slot(id_annul_slot), .id_ta_instr(id_ta_instr), .trap_ack(trap_ack),
        .pc_le(pc_w[0]), .npc_le(npc_w[0]), .if_le(if_w[0]), .if_squash(sq_w[0]),
        .nop_sel(nop_w[0]), .halted(halt_w[0]), .stall_count(sc_w[0]));

    pipeline_hazard_ctrl #(.FORWARDING(0), .MD_LAT(MD_LAT), .DRAIN_CYC(DRAIN_CYC)) dut_nofwd (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_rf_enable(id_rf_enable), .id_load_instr(id_load_instr), .id_muldiv(id_muldiv),
        .id_annul_slot(id_annul_slot), .id_ta_instr(id_ta_instr), .trap_ack(trap_ack),
        .pc_le(pc_w[1]), .npc_le(npc_w[1]), .if_le(if_w[1]), .if_squash(sq_w[1]),
        .nop_sel(nop_w[1]), .halted(halt_w[1]), .stall_count(sc_w[1]));

    // Model: history of the last three issued writers (index 0 = most recent = EX)
    bit         h_v  [2][3];
    bit         h_ld [2][3];
    logic [4:0] h_rd [2][3];
    int         m_md [2];
    int         m_drain [2];
    bit         m_halt [2];
    int         m_stall [2];

    function automatic bit model_hit(int k, logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
        if (k == 0) return h_v[k][0] && h_ld[k][0] && (h_rd[k][0] == rs);
        for (int j = 0; j < 3; j++)
            if (h_v[k][j] && (h_rd[k][j] == rs)) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [5:0] ev;  // {pc, npc, if, squash, nop, halted}
            logic [5:0] got;
            bit stall, issue;
            stall = 1'b0;
            issue = 1'b0;
            if (!reset) begin
                ev = 6'b000010;
                m_md[k] = 0; m_drain[k] = 0; m_halt[k] = 1'b0; m_stall[k] = 0;
                for (int j = 0; j < 3; j++) h_v[k][j] = 1'b0;
            end else if (m_halt[k]) begin
                ev = 6'b000011;
                if (trap_ack) m_halt[k] = 1'b0;
            end else if (m_drain[k] > 0) begin
                ev = 6'b000010;
                m_drain[k]--;
                if (m_drain[k] == 0) m_halt[k] = 1'b1;
            end else if (m_md[k] > 0) begin
                ev = 6'b000010;
                stall = 1'b1;
                m_md[k]--;
            end else if (id_valid && ((id_use_rs1 && model_hit(k, id_rs1)) ||
                                      (id_use_rs2 && model_hit(k, id_rs2)))) begin
                ev = 6'b000010;
                stall = 1'b1;
            end else begin
                ev = 6'b111000;
                issue = id_valid;
                if (id_valid && id_muldiv) m_md[k] = MD_LAT - 1;
                else if (id_valid && id_ta_instr) m_drain[k] = DRAIN_CYC;
                else if (id_valid && id_annul_slot) ev[2] = 1'b1;
            end
            got = {pc_w[k], npc_w[k], if_w[k], sq_w[k], nop_w[k], halt_w[k]};
            checks++;
            if (got !== ev) begin
                errors++;
                $display("FAIL ctrl[%0d] t=%0t got=%b required=%b", k, $time, got, ev);
            end
            checks++;
            if (sc_w[k] !== 16'(m_stall[k])) begin
                errors++;
                $display("FAIL stall_count[%0d] t=%0t got=%0d required=%0d", k, $time, sc_w[k], m_stall[k]);
            end
            if (reset) begin
                if (stall && m_stall[k] < 65535) m_stall[k]++;
                h_v[k][2] = h_v[k][1]; h_rd[k][2] = h_rd[k][1]; h_ld[k][2] = h_ld[k][1];
                h_v[k][1] = h_v[k][0]; h_rd[k][1] = h_rd[k][0]; h_ld[k][1] = h_ld[k][0];
                h_v[k][0]  = issue && id_rf_enable && (id_rd != 5'd0);
                h_rd[k][0] = id_rd;
                h_ld[k][0] = id_load_instr;
            end
        end
    end

    task automatic pin(string nm, int got, int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d required=%0d", nm, $time, got, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic obs();
        @(negedge clk);
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rd = 0;
        id_rf_enable = 0; id_load_instr = 0; id_muldiv = 0; id_annul_slot = 0;
        id_ta_instr = 0; trap_ack = 0;
    endtask

    task automatic instr(logic [4:0] rs1, bit u1, logic [4:0] rs2, bit u2, logic [4:0] rd,
                         bit rfen, bit ld);
        idle();
        id_valid = 1; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd; id_rf_enable = rfen; id_load_instr = ld;
    endtask

    task automatic do_reset();
        tick();
        reset = 0;
        idle();
        obs();
        pin("rst_pc_le", pc_w[0], 0);
        pin("rst_nop_sel", nop_w[0], 1);
        pin("rst_halted", halt_w[0], 0);
        tick();
        tick();
        reset = 1;
        obs();
        pin("rel_pc_le", pc_w[0], 1);
        pin("rel_if_le", if_w[1], 1);
        pin("rel_nop_sel", nop_w[0], 0);
        pin("rel_stall_count", sc_w[0], 0);
    endtask

    initial begin
        reset = 0;
        idle();
        do_reset();

        // Load r5 then add r3,r5,r5 (forwarding instance stalls exactly once)
        tick(); instr(5'd1, 1, 5'd0, 0, 5'd5, 1, 1); obs();
        tick(); instr(5'd5, 1, 5'd5, 1, 5'd3, 1, 0); obs();
        pin("lu_stall_pc", pc_w[0], 0);
        pin("lu_stall_nop", nop_w[0], 1);
        tick(); obs();
        pin("lu_issue_pc", pc_w[0], 1);
        pin("lu_stall_count", sc_w[0], 1);
        tick(); idle();

        // No forwarding: add r4 then sub reading r4 stalls three times
        do_reset();
        tick(); instr(5'd1, 1, 5'd2, 1, 5'd4, 1, 0); obs();
        for (int c = 0; c < 3; c++) begin
            tick(); instr(5'd4, 1, 5'd2, 1, 5'd6, 1, 0); obs();
            pin("raw_stall_pc", pc_w[1], 0);
        end
        tick(); obs();
        pin("raw_issue_pc", pc_w[1], 1);
        pin("raw_stall_count", sc_w[1], 3);
        tick(); instr(5'd1, 0, 5'd0, 0, 5'd0, 1, 0); obs();
        tick(); instr(5'd0, 1, 5'd0, 1, 5'd7, 1, 0); obs();
        pin("r0_no_stall", pc_w[1], 1);
        pin("r0_stall_count", sc_w[1], 3);

        // Multi-cycle mul occupies three extra cycles
        do_reset();
        tick(); idle(); id_valid = 1; id_muldiv = 1; id_annul_slot = 1; obs();
        pin("md_issue_squash", sq_w[0], 0);
        for (int c = 0; c < 3; c++) begin
            tick(); idle(); obs();
            pin("md_wait_pc", pc_w[0], 0);
            pin("md_wait_nop", nop_w[0], 1);
        end
        tick(); obs();
        pin("md_back_pc", pc_w[0], 1);
        pin("md_stall_count", sc_w[0], 3);

        // Annul behind a load-use hazard fires when the branch advances
        do_reset();
        tick(); instr(5'd1, 1, 5'd0, 0, 5'd7, 1, 1); obs();
        tick(); instr(5'd7, 1, 5'd0, 0, 5'd0, 0, 0); id_annul_slot = 1; obs();
        pin("an_stall_squash", sq_w[0], 0);
        pin("an_stall_pc", pc_w[0], 0);
        tick(); obs();
        pin("an_squash", sq_w[0], 1);
        pin("an_pc", pc_w[0], 1);
        tick(); idle(); obs();
        pin("an_after_squash", sq_w[0], 0);

        // Trap: drain three cycles, halt ten, early ack ignored, ack releases
        do_reset();
        tick(); idle(); id_valid = 1; id_ta_instr = 1; obs();
        pin("tr_issue_pc", pc_w[0], 1);
        for (int c = 0; c < 3; c++) begin
            tick(); idle(); trap_ack = (c == 1); obs();
            pin("tr_drain_halted", halt_w[0], 0);
            pin("tr_drain_pc", pc_w[0], 0);
        end
        for (int c = 0; c < 10; c++) begin
            tick(); idle(); obs();
            pin("tr_halted", halt_w[0], 1);
        end
        tick(); trap_ack = 1; obs();
        pin("tr_ack_cycle_halted", halt_w[0], 1);
        tick(); idle(); obs();
        pin("tr_released_halted", halt_w[0], 0);
        pin("tr_released_pc", pc_w[0], 1);
        pin("tr_stall_count", sc_w[0], 0);

        // Reset during drain aborts to RUN
        tick(); idle(); id_valid = 1; id_ta_instr = 1; obs();
        tick(); idle(); obs();
        tick(); reset = 0; obs();
        pin("trr_pc", pc_w[0], 0);
        pin("trr_halted", halt_w[0], 0);
        tick(); reset = 1; obs();
        pin("trr_rel_pc", pc_w[0], 1);
        for (int c = 0; c < 4; c++) begin
            tick(); obs();
            pin("trr_run_halted", halt_w[0], 0);
        end

        // Randomized traffic over a small register set to provoke hazards
        for (int i = 0; i < 4000; i++) begin
            tick();
            reset = ($urandom_range(0, 249) != 0);
            id_valid      = ($urandom_range(0, 9) < 8);
            id_rs1        = 5'($urandom_range(0, 7));
            id_rs2        = 5'($urandom_range(0, 7));
            id_use_rs1    = $urandom_range(0, 1) != 0;
            id_use_rs2    = $urandom_range(0, 1) != 0;
            id_rd         = 5'($urandom_range(0, 7));
            id_rf_enable  = ($urandom_range(0, 3) != 0);
            id_load_instr = ($urandom_range(0, 2) == 0);
            id_muldiv     = ($urandom_range(0, 19) == 0);
            id_ta_instr   = ($urandom_range(0, 39) == 0);
            id_annul_slot = ($urandom_range(0, 7) == 0);
            trap_ack      = ($urandom_range(0, 3) == 0);
        end
        tick();
        reset = 1;
        idle();
        obs();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the five-stage PPU pipeline: PC/nPC registers, IF/ID register, control-signal NOP mux, and ID/EX/MEM/WB control registers.
- Keeps an internal 3-slot destination scoreboard (EX, MEM, WB) and decides each cycle whether the pipeline advances, stalls, squashes the delay slot or drains.
- Generates the PC/nPC load enables, the IF/ID load and squash, and the NOP-mux select S.
- Also sequences multi-cycle hi/lo (mul/div) occupancy and the trap drain/halt.

Parameters:
- FORWARDING, 1: 1 = only load-use hazards against the EX slot stall; 0 = any RAW match in the EX, MEM or WB slot stalls.
- MD_LAT, 4: total cycles a mul/div occupies EX (≥2).
- DRAIN_CYC, 3: cycles to drain after a trap issues, before halting.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  5  source register 1
- id_rs2  in  5  source register 2
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2
- id_rd  in  5  destination register
- id_rf_enable  in  1  instruction writes the register file
- id_load_instr  in  1  instruction is a load
- id_muldiv  in  1  instruction writes hi/lo (multi-cycle)
- id_annul_slot  in  1  branch in ID annuls its delay slot
- id_ta_instr  in  1  trap instruction in ID
- trap_ack  in  1  one-cycle pulse releasing HALT
- pc_le  out  1  PC load enable
- npc_le  out  1  nPC load enable
- if_le  out  1  IF/ID register load enable
- if_squash  out  1  IF/ID register loads NOP
- nop_sel  out  1  S of the control mux (1 = zero control word into ID/EX)
- halted  out  1  pipeline halted after trap
- stall_count  out  16  saturating count of stall cycles

Behaviour:
- Reset (reset=0, async):
  - state=RUN, scoreboard slots invalid, md counter 0, drain counter 0, stall_count=0.
  - Outputs while reset is held: pc_le=npc_le=if_le=0, nop_sel=1, if_squash=0, halted=0.
- Scoreboard slot fields: {valid, rd, load}.
  - Each clk: WB<=MEM, MEM<=EX.
  - EX<={id_valid&id_rf_enable&(id_rd!=0)&!nop_sel, id_rd, id_load_instr}.
  - Shifting continues in every state; a bubble enters EX whenever nop_sel=1.
- hazard (combinational, RUN only, id_valid=1): for each used rs with rs!=0:
  - FORWARDING=1: match = EX.valid & EX.load & EX.rd==rs.
  - FORWARDING=0: match against valid EX, MEM or WB rd.
- Default advance (RUN, no hazard): pc_le=npc_le=if_le=1, nop_sel=0, if_squash=0.
- States:
  - RUN, hazard=1:
    - pc_le=npc_le=if_le=0, nop_sel=1, stall_count+1.
    - Annul and trap requests are ignored until the hazard clears.
  - RUN, advance with id_muldiv=1 (instruction issues this cycle): go to MD_WAIT, md counter<=MD_LAT-1.
  - MD_WAIT:
    - pc_le=npc_le=if_le=0, nop_sel=1, stall_count+1, counter-1.
    - When counter==1: next state RUN.
    - The instruction held in ID is re-evaluated in RUN.
  - RUN, advance with id_annul_slot=1: if_squash=1 for exactly that cycle; the IF/ID register loads NOP and the PC advances normally.
  - RUN, advance with id_ta_instr=1: trap issues, go to DRAIN, drain counter<=DRAIN_CYC.
  - DRAIN:
    - pc_le=npc_le=if_le=0, nop_sel=1, counter-1.
    - When counter==1: go to HALT.
    - stall_count does not increment.
  - HALT:
    - Same enables as DRAIN, halted=1.
    - trap_ack=1 moves to RUN next cycle; halted falls in the same edge.
- Priority within a cycle: reset > HALT/DRAIN > MD_WAIT > hazard > muldiv issue > trap issue > annul.
  - muldiv issue, trap issue and annul are decoded as mutually exclusive.
  - If several are asserted together, apply only the highest priority; the others are ignored.
- stall_count saturates at 16'hFFFF.
- trap_ack outside HALT is ignored.
- id_valid=0 never stalls and never issues; scoreboard receives a bubble.
- Reset assertion mid-MD_WAIT/DRAIN/HALT aborts immediately to the reset values.

Test Plan:
- Reset 0→1 with id_valid=0: pc_le=npc_le=if_le=1, nop_sel=0, halted=0, stall_count=0 on the first edge after release.
- FORWARDING=1, load r5 in ID, then add r3,r5,r5: exactly one cycle with pc_le=0, nop_sel=1; stall_count=1; the add issues on the next cycle.
- FORWARDING=0, add r4 then sub reading r4: three stall cycles (EX, MEM, WB matches), stall_count=3; a write to r0 causes no stall.
- MD_LAT=4, mul issues: next 3 cycles pc_le=0, nop_sel=1; back in RUN on the 4th; stall_count=3.
- Branch with id_annul_slot=1: if_squash=1 for one cycle, pc_le=1; if a load-use hazard coexists, the stall applies first and if_squash fires on the cycle the branch advances.
- Trap issue: 3 DRAIN cycles, then halted=1 held for 10 cycles; trap_ack pulse gives halted=0 and pc_le=1 next cycle; reset=0 during DRAIN gives halted=0 and state RUN after release.
